pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 152 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Qualifies the asynchronous PLL lock indication and releases the memory,
// co-processor and CPU resets in that order, each a fixed number of clocks
// after the previous one. Loss of lock after any release is flagged and counted.
`timescale 1ns/1ps

module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             sw_reset_req,
  input  logic             clear_lost,
  output logic             rst_memory,
  output logic             rst_copro,
  output logic             rst_cpu,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lock_lost_count
);

  // The shared counter only has to reach the longer of the two waits.
  localparam int MAX_WAIT = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int CTR_W    = $clog2(MAX_WAIT);

  localparam logic [CTR_W-1:0] STABLE_LAST = CTR_W'(STABLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] GAP_LAST    = CTR_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  localparam logic [2:0] S_HOLD      = 3'd0;
  localparam logic [2:0] S_STABLE    = 3'd1;
  localparam logic [2:0] S_REL_MEM   = 3'd2;
  localparam logic [2:0] S_REL_COPRO = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [2:0]             state;
  logic [2:0]             next_state;
  logic [CTR_W-1:0]       counter;
  logic                   restart;
  logic                   lost_event;

  // Synchronise the raw lock indication into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state decision; lock loss outranks a software request, which outranks the timers.
  always_comb begin
    next_state = state;
    lost_event = 1'b0;
    restart    = 1'b0;
    case (state)
      S_HOLD: begin
        if (locked_s) next_state = S_STABLE;
      end
      S_STABLE: begin
        if (!locked_s)                    next_state = S_HOLD;
        else if (sw_reset_req)            restart    = 1'b1;
        else if (counter == STABLE_LAST)  next_state = S_REL_MEM;
      end
      S_REL_MEM: begin
        if (!locked_s) begin
          next_state = S_HOLD;
          lost_event = 1'b1;
        end else if (sw_reset_req) begin
          next_state = S_STABLE;
        end else if (counter == GAP_LAST) begin
          next_state = S_REL_COPRO;
        end
      end
      S_REL_COPRO: begin
        if (!locked_s) begin
          next_state = S_HOLD;
          lost_event = 1'b1;
        end else if (sw_reset_req) begin
          next_state = S_STABLE;
        end else if (counter == GAP_LAST) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          next_state = S_HOLD;
          lost_event = 1'b1;
        end else if (sw_reset_req) begin
          next_state = S_STABLE;
        end
      end
      default: begin
        next_state = S_HOLD;
      end
    endcase
    if (next_state != state) restart = 1'b1;
  end

  // State register and the shared wait counter, which restarts on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_HOLD;
      counter <= '0;
    end else begin
      state   <= next_state;
      counter <= restart ? '0 : counter + CTR_W'(1);
    end
  end

  // Reset outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_memory <= 1'b1;
      rst_copro  <= 1'b1;
      rst_cpu    <= 1'b1;
      ready      <= 1'b0;
    end else begin
      rst_memory <= !(next_state == S_REL_MEM || next_state == S_REL_COPRO || next_state == S_RUN);
      rst_copro  <= !(next_state == S_REL_COPRO || next_state == S_RUN);
      rst_cpu    <= (next_state != S_RUN);
      ready      <= (next_state == S_RUN);
    end
  end

  // Sticky loss flag and saturating loss counter; a new loss beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_lost       <= 1'b0;
      lock_lost_count <= '0;
    end else if (lost_event) begin
      lock_lost <= 1'b1;
      if (clear_lost) begin
        lock_lost_count <= CNT_W'(1);
      end else if (lock_lost_count != CNT_MAX) begin
        lock_lost_count <= lock_lost_count + CNT_W'(1);
      end
    end else if (clear_lost) begin
      lock_lost       <= 1'b0;
      lock_lost_count <= '0;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Drives directed and random lock/software-reset/clear patterns and compares the
// DUT every cycle against a timeline model: once qualification starts, the
// elapsed edge count alone decides which resets are released.
`timescale 1ns/1ps

module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int STAB = 8;
  localparam int GAP  = 4;
  localparam int CW   = 2;
  localparam int CMAX = 3;
  localparam logic [6:0] RESET_VEC = 7'b1110000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          sw_reset_req = 1'b0;
  logic          clear_lost = 1'b0;
  logic          rst_memory;
  logic          rst_copro;
  logic          rst_cpu;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] lock_lost_count;
  logic [6:0]    obs;

  int total = 0;
  int bad   = 0;

  // model state
  bit [SYNC-1:0] m_hist;
  bit            m_active;
  int            m_t;
  bit            m_flag;
  int            m_count;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC),
    .STABLE_CYCLES(STAB),
    .STAGE_GAP(GAP),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req),
    .clear_lost(clear_lost),
    .rst_memory(rst_memory),
    .rst_copro(rst_copro),
    .rst_cpu(rst_cpu),
    .ready(ready),
    .lock_lost(lock_lost),
    .lock_lost_count(lock_lost_count)
  );

  assign obs = {rst_memory, rst_copro, rst_cpu, ready, lock_lost, lock_lost_count};

  always #5 clock = ~clock;

  task automatic model_reset();
    m_hist   = '0;
    m_active = 1'b0;
    m_t      = 0;
    m_flag   = 1'b0;
    m_count  = 0;
  endtask

  // One clock edge of the model: m_t is edges since qualification began.
  task automatic model_update();
    bit ls;
    bit lost;
    ls   = m_hist[SYNC-1];
    lost = 1'b0;
    if (!m_active) begin
      if (ls) begin
        m_active = 1'b1;
        m_t      = 0;
      end
    end else if (!ls) begin
      lost     = (m_t >= STAB);
      m_active = 1'b0;
    end else if (sw_reset_req) begin
      m_t = 0;
    end else if (m_t < 100000) begin
      m_t = m_t + 1;
    end
    if (lost) begin
      m_flag  = 1'b1;
      m_count = clear_lost ? 1 : ((m_count < CMAX) ? m_count + 1 : CMAX);
    end else if (clear_lost) begin
      m_flag  = 1'b0;
      m_count = 0;
    end
    m_hist = {m_hist[SYNC-2:0], pll_locked};
  endtask

  function automatic logic [6:0] exp_vec();
    logic mem_rel;
    logic cop_rel;
    logic cpu_rel;
    mem_rel = m_active && (m_t >= STAB);
    cop_rel = m_active && (m_t >= STAB + GAP);
    cpu_rel = m_active && (m_t >= STAB + 2 * GAP);
    return {!mem_rel, !cop_rel, !cpu_rel, cpu_rel, m_flag, 2'(m_count)};
  endfunction

  task automatic step();
    @(posedge clock);
    if (!reset) model_update();
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pll_locked = 1'b1;
    reset      = 1'b1;
    model_reset();
    for (int e = 1; e <= 3; e++) begin
      step();
      total++;
      if (obs !== RESET_VEC) begin
        bad++;
        $display("[TB] FAIL reset_hold edge=%0d obs=%b exp=%b", e, obs, RESET_VEC);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_power_up();
    int mem_e = -1;
    int cop_e = -1;
    int cpu_e = -1;
    int rdy_e = -1;
    for (int e = 1; e <= 30; e++) begin
      step();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL power_up edge=%0d obs=%b exp=%b", e, obs, exp_vec());
      end
      if (mem_e < 0 && !rst_memory) mem_e = e;
      if (cop_e < 0 && !rst_copro)  cop_e = e;
      if (cpu_e < 0 && !rst_cpu)    cpu_e = e;
      if (rdy_e < 0 && ready)       rdy_e = e;
    end
    total++;
    if (mem_e != 11 || cop_e != 15 || cpu_e != 19 || rdy_e != 19) begin
      bad++;
      $display("[TB] FAIL power_up_edges got mem=%0d copro=%0d cpu=%0d ready=%0d want 11/15/19/19",
               mem_e, cop_e, cpu_e, rdy_e);
    end
    total++;
    if (lock_lost !== 1'b0) begin
      bad++;
      $display("[TB] FAIL power_up_flag got %b want 0", lock_lost);
    end
  endtask

  task automatic test_glitch();
    int mem_e = -1;
    pulse_reset();
    pll_locked = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      pll_locked = (e == 5) ? 1'b0 : 1'b1;
      step();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL glitch edge=%0d obs=%b exp=%b", e, obs, exp_vec());
      end
      if (mem_e < 0 && !rst_memory) mem_e = e;
    end
    total++;
    if (mem_e != 16 || lock_lost !== 1'b0 || lock_lost_count !== 2'd0) begin
      bad++;
      $display("[TB] FAIL glitch_restart got mem=%0d flag=%b count=%0d want 16/0/0",
               mem_e, lock_lost, lock_lost_count);
    end
  endtask

  task automatic test_loss_run();
    int hold_e = -1;
    for (int e = 1; e <= 40; e++) begin
      pll_locked = (e <= 3) ? 1'b0 : 1'b1;
      step();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL loss_run edge=%0d obs=%b exp=%b", e, obs, exp_vec());
      end
      if (hold_e < 0 && rst_memory && rst_copro && rst_cpu && !ready) hold_e = e;
    end
    total++;
    if (hold_e != 3 || lock_lost !== 1'b1 || lock_lost_count !== 2'd1 || ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL loss_run_result got hold=%0d flag=%b count=%0d ready=%b want 3/1/1/1",
               hold_e, lock_lost, lock_lost_count, ready);
    end
  endtask

  task automatic test_saturation();
    int want [5] = '{1, 2, 3, 3, 3};
    clear_lost = 1'b1;
    step();
    clear_lost = 1'b0;
    total++;
    if (lock_lost !== 1'b0 || lock_lost_count !== 2'd0) begin
      bad++;
      $display("[TB] FAIL sat_clear0 got flag=%b count=%0d want 0/0", lock_lost, lock_lost_count);
    end
    for (int k = 0; k < 6; k++) begin
      for (int e = 1; e <= 30; e++) begin
        pll_locked = (e <= 3) ? 1'b0 : 1'b1;
        clear_lost = (k == 5 && e == 3) ? 1'b1 : 1'b0;
        step();
        clear_lost = 1'b0;
        total++;
        if (obs !== exp_vec()) begin
          bad++;
          $display("[TB] FAIL saturation k=%0d edge=%0d obs=%b exp=%b", k, e, obs, exp_vec());
        end
      end
      if (k < 5) begin
        total++;
        if (lock_lost !== 1'b1 || int'(lock_lost_count) != want[k]) begin
          bad++;
          $display("[TB] FAIL sat_count k=%0d got flag=%b count=%0d want 1/%0d",
                   k, lock_lost, lock_lost_count, want[k]);
        end
      end else begin
        total++;
        if (lock_lost !== 1'b1 || lock_lost_count !== 2'd1) begin
          bad++;
          $display("[TB] FAIL sat_clear_vs_loss got flag=%b count=%0d want 1/1",
                   lock_lost, lock_lost_count);
        end
      end
      if (k == 4) begin
        clear_lost = 1'b1;
        step();
        clear_lost = 1'b0;
        total++;
        if (lock_lost !== 1'b0 || lock_lost_count !== 2'd0) begin
          bad++;
          $display("[TB] FAIL sat_clear got flag=%b count=%0d want 0/0", lock_lost, lock_lost_count);
        end
        for (int e = 1; e <= 30; e++) step();
      end
    end
  endtask

  task automatic test_sw_reset();
    int mem_e = -1;
    int cop_e = -1;
    int cpu_e = -1;
    pll_locked   = 1'b1;
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    total++;
    if (obs[6:3] !== 4'b1110) begin
      bad++;
      $display("[TB] FAIL sw_run_assert got %b want 1110", obs[6:3]);
    end
    for (int e = 2; e <= 22; e++) begin
      step();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL sw_run edge=%0d obs=%b exp=%b", e, obs, exp_vec());
      end
      if (mem_e < 0 && !rst_memory) mem_e = e;
      if (cop_e < 0 && !rst_copro)  cop_e = e;
      if (cpu_e < 0 && !rst_cpu)    cpu_e = e;
    end
    total++;
    if (mem_e != 9 || cop_e != 13 || cpu_e != 17) begin
      bad++;
      $display("[TB] FAIL sw_run_edges got %0d/%0d/%0d want 9/13/17", mem_e, cop_e, cpu_e);
    end
    pll_locked = 1'b0;
    pulse_reset();
    for (int e = 1; e <= 9; e++) begin
      sw_reset_req = (e == 5) ? 1'b1 : 1'b0;
      step();
      sw_reset_req = 1'b0;
      total++;
      if (obs !== RESET_VEC) begin
        bad++;
        $display("[TB] FAIL sw_hold edge=%0d obs=%b exp=%b", e, obs, RESET_VEC);
      end
    end
    pll_locked = 1'b1;
    mem_e = -1;
    for (int e = 1; e <= 20; e++) begin
      step();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL sw_hold_seq edge=%0d obs=%b exp=%b", e, obs, exp_vec());
      end
      if (mem_e < 0 && !rst_memory) mem_e = e;
    end
    total++;
    if (mem_e != 11) begin
      bad++;
      $display("[TB] FAIL sw_hold_mem got %0d want 11", mem_e);
    end
  endtask

  task automatic test_async_reset();
    int mem_e = -1;
    int cpu_e = -1;
    pulse_reset();
    pll_locked = 1'b1;
    for (int e = 1; e <= 16; e++) step();
    total++;
    if (obs[6:3] !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL async_pre got %b want 0010", obs[6:3]);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("[TB] FAIL async_immediate got %b want %b", obs, RESET_VEC);
    end
    step();
    reset = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      step();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL async_seq edge=%0d obs=%b exp=%b", e, obs, exp_vec());
      end
      if (mem_e < 0 && !rst_memory) mem_e = e;
      if (cpu_e < 0 && !rst_cpu)    cpu_e = e;
    end
    total++;
    if (mem_e != 11 || cpu_e != 19) begin
      bad++;
      $display("[TB] FAIL async_restart got mem=%0d cpu=%0d want 11/19", mem_e, cpu_e);
    end
  endtask

  task automatic test_random();
    int drop_left = 0;
    for (int e = 1; e <= 2000; e++) begin
      if (drop_left > 0) begin
        pll_locked = 1'b0;
        drop_left--;
      end else if ($urandom_range(0, 79) == 0) begin
        pll_locked = 1'b0;
        drop_left  = int'($urandom_range(0, 3));
      end else begin
        pll_locked = 1'b1;
      end
      sw_reset_req = ($urandom_range(0, 59) == 0);
      clear_lost   = ($urandom_range(0, 89) == 0);
      step();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL random edge=%0d obs=%b exp=%b", e, obs, exp_vec());
      end
    end
    sw_reset_req = 1'b0;
    clear_lost   = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_up();
    test_glitch();
    test_loss_run();
    test_saturation();
    test_sw_reset();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
